// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encoding, instruction width and opcodes shared with branch control.
package fetch_sequencer_pkg;
  localparam int INST_W = 16;
  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OPC_JAL = 5'b11111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_ALUI = 5'b00100;
  typedef enum logic [2:0] {IDLE, FETCH, DROP, HOLD, HALTED} state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction memory, decode, redirect and halt signals of the fetch sequencer.
interface fetch_sequencer_if import fetch_sequencer_pkg::*; #(parameter int BITS = 16);
  logic imem_req;
  logic [BITS-1:0] imem_addr;
  logic imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic inst_valid;
  logic [INST_W-1:0] inst;
  logic [BITS-1:0] inst_pc;
  logic dec_ready;
  logic redirect_valid;
  logic [BITS-1:0] redirect_pc;
  logic halt;
  logic resume;
  logic busy;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, busy,
    input imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, halt, resume
  );
  modport slave (
    input imem_req, imem_addr, inst_valid, inst, inst_pc, busy,
    output imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc, halt, resume
  );
endinterface

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: 16-bit saturating event counter, present only with FETCH_SEQ_PERF_EN.
`ifdef FETCH_SEQ_PERF_EN
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (inc_i && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule
`endif

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with redirect, halt and decode hand-off.
// FETCH_SEQ_PERF_EN adds perf_fetch/perf_stall saturating counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int BITS = 16,
  parameter int OP_BITS = 5,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.master bus
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_stall
`endif
);
  if (OP_BITS < OPC_W) begin : g_op_bits_chk
    $error("OP_BITS narrower than the shared opcode constants");
  end
  state_e state_q, state_d;
  logic [BITS-1:0] pc_q, pc_d, faddr_q, faddr_d, inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic halt_pend_q, halt_pend_d, hp, deliver;
  // a halt request seen this cycle counts as pending for the drain decision
  assign hp = halt_pend_q | bus.halt;
  assign deliver = state_q == FETCH && bus.imem_ack && !bus.redirect_valid;
  always_comb begin
    pc_d = bus.redirect_valid ? bus.redirect_pc : deliver ? faddr_q + 1'b1 : pc_q;
    inst_d = deliver ? bus.imem_rdata : inst_q;
    inst_pc_d = deliver ? faddr_q : inst_pc_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hp ? HALTED : FETCH;
      FETCH:   state_d = !bus.imem_ack ? (bus.redirect_valid ? DROP : FETCH)
                                       : (bus.redirect_valid ? IDLE : HOLD);
      DROP:    state_d = !bus.imem_ack ? DROP : hp ? IDLE : FETCH;
      HOLD:    state_d = !(bus.redirect_valid || bus.dec_ready) ? HOLD : hp ? IDLE : FETCH;
      HALTED:  state_d = (bus.resume && !bus.halt) ? FETCH : HALTED;
      default: state_d = IDLE;
    endcase
    faddr_d = (state_d == FETCH && state_q != FETCH) ? pc_d : faddr_q;
    halt_pend_d = hp && state_d != HALTED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      faddr_q <= RESET_PC;
      inst_q <= '0;
      inst_pc_q <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      faddr_q <= faddr_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      halt_pend_q <= halt_pend_d;
    end
  assign bus.imem_req = state_q == FETCH || state_q == DROP;
  assign bus.imem_addr = faddr_q;
  assign bus.inst_valid = state_q == HOLD;
  assign bus.inst = inst_q;
  assign bus.inst_pc = inst_pc_q;
  assign bus.busy = state_q != HALTED;
`ifdef FETCH_SEQ_PERF_EN
  fetch_perf_ctr u_perf_fetch (.clk(clk), .rst_n(rst_n), .inc_i(deliver), .cnt_o(perf_fetch));
  fetch_perf_ctr u_perf_stall (.clk(clk), .rst_n(rst_n), .inc_i(state_q == HOLD && !bus.dec_ready), .cnt_o(perf_stall));
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus, per-cycle check against a flag-based model plus literal checkpoints.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  fetch_sequencer_if #(.BITS(16)) bus ();
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] perf_fetch, perf_stall;
`endif
  fetch_sequencer #(.BITS(16), .OP_BITS(5), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;

  logic [15:0] m_pc, m_addr, m_inst, m_ipc, m_fetch, m_stall;
  bit m_req, m_drop, m_valid, m_halted, m_hp;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_addr = 16'h0; m_inst = 16'h0; m_ipc = 16'h0;
    m_fetch = 16'h0; m_stall = 16'h0;
    m_req = 0; m_drop = 0; m_valid = 0; m_halted = 0; m_hp = 0;
  endtask

  task automatic launch();
    m_req = 1; m_drop = 0; m_addr = m_pc;
  endtask

  task automatic model_step();
    bit hp;
    hp = m_hp | bus.halt;
    if (bus.redirect_valid) m_pc = bus.redirect_pc;
    if (m_halted) begin
      if (bus.resume && !bus.halt) begin m_halted = 0; launch(); end
    end else if (m_valid) begin
      if (!bus.dec_ready && m_stall != 16'hFFFF) m_stall++;
      if (bus.redirect_valid || bus.dec_ready) begin
        m_valid = 0;
        if (hp) m_req = 0; else launch();
      end
    end else if (m_req) begin
      if (bus.imem_ack && !m_drop && !bus.redirect_valid) begin
        m_req = 0; m_valid = 1; m_inst = bus.imem_rdata; m_ipc = m_addr; m_pc = m_addr + 16'd1;
        if (m_fetch != 16'hFFFF) m_fetch++;
      end else if (bus.imem_ack && !m_drop) m_req = 0;
      else if (bus.imem_ack) begin
        if (hp) m_req = 0; else launch();
      end else if (bus.redirect_valid) m_drop = 1;
    end else begin
      if (hp) m_halted = 1; else launch();
    end
    m_hp = hp && !m_halted;
  endtask

  always @(negedge clk) begin
    chk("req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("addr", 32'(bus.imem_addr), 32'(m_addr));
    chk("valid", 32'(bus.inst_valid), 32'(m_valid));
    if (m_valid) begin
      chk("inst", 32'(bus.inst), 32'(m_inst));
      chk("inst_pc", 32'(bus.inst_pc), 32'(m_ipc));
    end
    chk("busy", 32'(bus.busy), 32'(!m_halted));
`ifdef FETCH_SEQ_PERF_EN
    chk("perf_fetch", 32'(perf_fetch), 32'(m_fetch));
    chk("perf_stall", 32'(perf_stall), 32'(m_stall));
`endif
  end

  task automatic cyc(input int a = 0, d = 0, dr = 0, rv = 0, rp = 0, h = 0, rs = 0);
    bus.imem_ack = a[0];
    bus.imem_rdata = 16'(d);
    bus.dec_ready = dr[0];
    bus.redirect_valid = rv[0];
    bus.redirect_pc = 16'(rp);
    bus.halt = h[0];
    bus.resume = rs[0];
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.dec_ready = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 0; bus.halt = 0; bus.resume = 0;
    model_reset();
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", 32'(bus.inst), 32'h0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    // first fetch, ack on the second request cycle
    cyc();
    chk("first_req", 32'(bus.imem_req), 32'h1);
    chk("first_addr", 32'(bus.imem_addr), 32'h0);
    cyc();
    cyc(1, 'hA5A5, 1);
    chk("first_inst", 32'(bus.inst), 32'hA5A5);
    chk("first_inst_pc", 32'(bus.inst_pc), 32'h0);
    cyc(0, 0, 1);
    chk("second_addr", 32'(bus.imem_addr), 32'h1);
    // decode stall
    cyc(1, 'h1234);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_inst", 32'(bus.inst), 32'h1234);
      chk("stall_noreq", 32'(bus.imem_req), 32'h0);
    end
`ifdef FETCH_SEQ_PERF_EN
    chk("lit_perf_stall", 32'(perf_stall), 32'd5);
    chk("lit_perf_fetch", 32'(perf_fetch), 32'd2);
`endif
    cyc(0, 0, 1);
    // redirect during an outstanding fetch
    cyc(0, 0, 0, 1, 'h40);
    chk("drop_addr_held", 32'(bus.imem_addr), 32'h2);
    cyc();
    cyc();
    cyc(1, 'hDEAD);
    chk("drop_no_valid", 32'(bus.inst_valid), 32'h0);
    chk("redir_addr", 32'(bus.imem_addr), 32'h40);
    cyc(1, 'h1111);
    chk("redir_inst_pc", 32'(bus.inst_pc), 32'h40);
    cyc(0, 0, 1);
    // redirect coinciding with ack, stray ack while idle
    cyc(1, 'hBEEF, 0, 1, 'h10);
    chk("gap_req", 32'(bus.imem_req), 32'h0);
    cyc(1, 'hCAFE);
    chk("gap_addr", 32'(bus.imem_addr), 32'h10);
    chk("gap_valid", 32'(bus.inst_valid), 32'h0);
    // halt during fetch, drain, then halt+resume, then resume
    cyc(0, 0, 0, 0, 0, 1);
    chk("halt_still_req", 32'(bus.imem_req), 32'h1);
    cyc(1, 'h2222);
    chk("halt_inst_pc", 32'(bus.inst_pc), 32'h10);
    cyc(0, 0, 1);
    cyc();
    chk("halted_busy", 32'(bus.busy), 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("halt_wins_busy", 32'(bus.busy), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("resume_addr", 32'(bus.imem_addr), 32'h11);
    // PC wrap
    cyc(1, 'h9999, 0, 1, 'hFFFF);
    cyc();
    chk("wrap_top", 32'(bus.imem_addr), 32'hFFFF);
    cyc(1, 'h3333);
    cyc(0, 0, 1);
    chk("wrap_zero", 32'(bus.imem_addr), 32'h0);
    // redirect in HOLD drops the instruction even with dec_ready
    cyc(1, 'h4444);
    cyc(0, 0, 1, 1, 'h80);
    chk("hold_redir_addr", 32'(bus.imem_addr), 32'h80);
    // redirect and halt together, then redirect while halted
    cyc(0, 0, 0, 1, 'h90, 1);
    cyc(1, 'h5555);
    cyc();
    chk("rh_busy", 32'(bus.busy), 32'h0);
    cyc(0, 0, 0, 1, 'h55);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("halted_redir_addr", 32'(bus.imem_addr), 32'h55);
    // reset mid-access
    cyc();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("midrst_req", 32'(bus.imem_req), 32'h0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc(1, 'h7777, 1);
    chk("postrst_inst", 32'(bus.inst), 32'h7777);
    cyc(0, 0, 1);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
